// File: rtl/vga_pattern_timing_gen.sv
// Programmable VGA timing generator with five runtime-selectable test patterns; counter-to-pin latency is 2 clk.
// Optional build macro VGA_BIT_REPLICATE_EN: RGB565 expansion by MSB replication instead of zero fill.
module vga_pattern_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int GRID     = 32
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [2:0]  mode_sel,
  input  logic [23:0] solid_rgb,
  input  logic [15:0] ext_pix_data,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        hs_out,
  output logic        vs_out,
  output logic        de_out,
  output logic [7:0]  r_out,
  output logic [7:0]  g_out,
  output logic [7:0]  b_out,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam logic [15:0] H_LAST    = 16'(H_SYNC + H_BACK + H_ACTIVE + H_FRONT - 1);
  localparam logic [15:0] H_AST     = 16'(H_SYNC + H_BACK);
  localparam logic [15:0] H_AEND    = 16'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [15:0] H_SYN     = 16'(H_SYNC);
  localparam logic [15:0] V_LAST    = 16'(V_SYNC + V_BACK + V_ACTIVE + V_FRONT - 1);
  localparam logic [15:0] V_AST     = 16'(V_SYNC + V_BACK);
  localparam logic [15:0] V_AEND    = 16'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [15:0] V_SYN     = 16'(V_SYNC);
  localparam logic [11:0] BAR_LAST  = 12'(H_ACTIVE / 8 - 1);
  localparam logic [11:0] GRID_LAST = 12'(GRID - 1);
  localparam logic [11:0] X_LAST    = 12'(H_ACTIVE - 1);
  localparam logic [11:0] Y_LAST    = 12'(V_ACTIVE - 1);
  localparam logic        HS_ACT    = (HS_POL != 0);
  localparam logic        VS_ACT    = (VS_POL != 0);

  function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
`ifdef VGA_BIT_REPLICATE_EN
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
`else
    return {d[15:11], 3'b000, d[10:5], 2'b00, d[4:0], 3'b000};
`endif
  endfunction

  logic [15:0] h_q, h_d, v_q, v_d;
  logic [2:0]  mode_q, mode_d, bar_q, bar_d;
  logic [11:0] barpx_q, barpx_d, gx_q, gx_d, gy_q, gy_d;
  logic        de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, fs1_q, fs1_d, ext1_q, ext1_d;
  logic [23:0] rgb1_q, rgb1_d;
  logic        de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d;
  logic [23:0] rgb_q, rgb_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  logic h_act_s, v_act_s, act_s, h_end_s, f_end_s;

  assign h_act_s = (h_q >= H_AST) && (h_q < H_AEND);
  assign v_act_s = (v_q >= V_AST) && (v_q < V_AEND);
  assign act_s   = h_act_s && v_act_s;
  assign h_end_s = (h_q == H_LAST);
  assign f_end_s = h_end_s && (v_q == V_LAST);
  assign pix_x   = act_s ? 12'(h_q - H_AST) : 12'hFFF;
  assign pix_y   = act_s ? 12'(v_q - V_AST) : 12'hFFF;

  // Next-state for counters, pattern stage (stage 1) and output stage (stage 2)
  always_comb begin
    h_d = h_end_s ? 16'd0 : h_q + 16'd1;
    if (h_end_s) begin
      v_d = (v_q == V_LAST) ? 16'd0 : v_q + 16'd1;
    end else begin
      v_d = v_q;
    end
    mode_d = f_end_s ? mode_sel : mode_q;

    // Bar and grid positions are tracked by counters so no divider or modulo is needed
    if (h_act_s) begin
      if (barpx_q == BAR_LAST) begin
        barpx_d = 12'd0;
        bar_d   = bar_q + 3'd1;
      end else begin
        barpx_d = barpx_q + 12'd1;
        bar_d   = bar_q;
      end
      gx_d = (gx_q == GRID_LAST) ? 12'd0 : gx_q + 12'd1;
    end else begin
      barpx_d = 12'd0;
      bar_d   = 3'd0;
      gx_d    = 12'd0;
    end
    if (h_end_s) begin
      if (v_act_s) begin
        gy_d = (gy_q == GRID_LAST) ? 12'd0 : gy_q + 12'd1;
      end else begin
        gy_d = 12'd0;
      end
    end else begin
      gy_d = gy_q;
    end

    de1_d  = act_s;
    hs1_d  = (h_q < H_SYN) ? HS_ACT : ~HS_ACT;
    vs1_d  = (v_q < V_SYN) ? VS_ACT : ~VS_ACT;
    fs1_d  = (h_q == 16'd0) && (v_q == 16'd0);
    ext1_d = (mode_q == 3'd4);
    rgb1_d = 24'h000000;
    case (mode_q)
      3'd0: begin
        case (bar_q)
          3'd0:    rgb1_d = 24'hFFFFFF;
          3'd1:    rgb1_d = 24'hFFFF00;
          3'd2:    rgb1_d = 24'h00FFFF;
          3'd3:    rgb1_d = 24'h00FF00;
          3'd4:    rgb1_d = 24'hFF00FF;
          3'd5:    rgb1_d = 24'hFF0000;
          3'd6:    rgb1_d = 24'h0000FF;
          default: rgb1_d = 24'h000000;
        endcase
      end
      3'd1: begin
        if ((gx_q == 12'd0) || (gy_q == 12'd0) || (pix_x == X_LAST) || (pix_y == Y_LAST)) begin
          rgb1_d = 24'hFFFFFF;
        end else begin
          rgb1_d = 24'h000000;
        end
      end
      3'd2:    rgb1_d = {pix_x[7:0], pix_y[7:0], frame_cnt_q[7:0]};
      3'd3:    rgb1_d = solid_rgb;
      default: rgb1_d = 24'h000000;
    endcase

    de_d = de1_q;
    hs_d = hs1_q;
    vs_d = vs1_q;
    fs_d = fs1_q;
    frame_cnt_d = fs1_q ? frame_cnt_q + 16'd1 : frame_cnt_q;
    // External pixels arrive one clk after pix_x, i.e. alongside stage 1
    if (!de1_q) begin
      rgb_d = 24'h000000;
    end else if (ext1_q) begin
      rgb_d = rgb565_to_888(ext_pix_data);
    end else begin
      rgb_d = rgb1_q;
    end
  end

  // State and pipeline registers
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_q <= 16'd0;        v_q <= 16'd0;        mode_q <= 3'd0;
      bar_q <= 3'd0;       barpx_q <= 12'd0;    gx_q <= 12'd0;     gy_q <= 12'd0;
      de1_q <= 1'b0;       hs1_q <= ~HS_ACT;    vs1_q <= ~VS_ACT;
      fs1_q <= 1'b0;       ext1_q <= 1'b0;      rgb1_q <= 24'h000000;
      de_q <= 1'b0;        hs_q <= ~HS_ACT;     vs_q <= ~VS_ACT;
      fs_q <= 1'b0;        rgb_q <= 24'h000000; frame_cnt_q <= 16'd0;
    end else begin
      h_q <= h_d;          v_q <= v_d;          mode_q <= mode_d;
      bar_q <= bar_d;      barpx_q <= barpx_d;  gx_q <= gx_d;      gy_q <= gy_d;
      de1_q <= de1_d;      hs1_q <= hs1_d;      vs1_q <= vs1_d;
      fs1_q <= fs1_d;      ext1_q <= ext1_d;    rgb1_q <= rgb1_d;
      de_q <= de_d;        hs_q <= hs_d;        vs_q <= vs_d;
      fs_q <= fs_d;        rgb_q <= rgb_d;      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign hs_out      = hs_q;
  assign vs_out      = vs_q;
  assign de_out      = de_q;
  assign r_out       = rgb_q[23:16];
  assign g_out       = rgb_q[15:8];
  assign b_out       = rgb_q[7:0];
  assign frame_start = fs_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_timing_gen.sv
// Randomized bench for vga_pattern_timing_gen on a reduced raster; the expected pins are derived
// from the elapsed-cycle count since reset (position = cycles - 2) with plain arithmetic.
module tb_vga_pattern_timing_gen;

  localparam int HS = 4, HB = 3, HA = 32, HF = 2;
  localparam int VS = 2, VB = 2, VA = 12, VF = 1;
  localparam int GR = 4;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int FT = HT * VT;
  localparam int HAS = HS + HB;
  localparam int VAS = VS + VB;
`ifdef VGA_BIT_REPLICATE_EN
  localparam logic [23:0] EXT_FULL = 24'hFFFFFF;
`else
  localparam logic [23:0] EXT_FULL = 24'hF8FCF8;
`endif

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [2:0]  mode_sel = 3'd0;
  logic [23:0] solid_rgb = 24'h0;
  logic [15:0] ext_pix_data = 16'h0;
  logic [11:0] pix_x, pix_y;
  logic        hs_out, vs_out, de_out, frame_start;
  logic [7:0]  r_out, g_out, b_out;
  logic [15:0] frame_cnt;

  int total = 0;
  int bad = 0;
  int n = 0;
  int chg_at = 1;
  logic [2:0]  nxt_mode = 3'd0;
  logic [2:0]  fmode [64];
  logic [23:0] fsolid [64];
  logic [15:0] ext_tab [32];
  logic [11:0] prev_x = 12'hFFF, prev_y = 12'hFFF;

  always #5 vga_clk = ~vga_clk;

  vga_pattern_timing_gen #(
    .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
    .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
    .HS_POL(0), .VS_POL(0), .GRID(GR)
  ) dut (
    .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .mode_sel(mode_sel), .solid_rgb(solid_rgb),
    .ext_pix_data(ext_pix_data), .pix_x(pix_x), .pix_y(pix_y), .hs_out(hs_out), .vs_out(vs_out),
    .de_out(de_out), .r_out(r_out), .g_out(g_out), .b_out(b_out), .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, n, got, exp);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] d);
`ifdef VGA_BIT_REPLICATE_EN
    return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
`else
    return {d[15:11], 3'b000, d[10:5], 2'b00, d[4:0], 3'b000};
`endif
  endfunction

  function automatic logic [15:0] src(input logic [11:0] x, input logic [11:0] y);
    logic [11:0] s;
    s = x + y;
    return ext_tab[s[4:0]];
  endfunction

  function automatic logic [23:0] exp_rgb(input int ax, input int ay, input int f,
                                          input logic [2:0] m, input logic [23:0] s);
    logic [23:0] r;
    r = 24'h0;
    case (m)
      3'd0: begin
        case (ax / (HA / 8))
          0: r = 24'hFFFFFF;
          1: r = 24'hFFFF00;
          2: r = 24'h00FFFF;
          3: r = 24'h00FF00;
          4: r = 24'hFF00FF;
          5: r = 24'hFF0000;
          6: r = 24'h0000FF;
          default: r = 24'h000000;
        endcase
      end
      3'd1: if (ax % GR == 0 || ay % GR == 0 || ax == HA - 1 || ay == VA - 1) r = 24'hFFFFFF;
      3'd2: r = {8'(ax), 8'(ay), 8'(f + 1)};
      3'd3: r = s;
      3'd4: r = expand(ext_tab[5'(ax + ay)]);
      default: r = 24'h0;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] plan(input int f);
    case (f)
      1: return 3'd1;
      2: return 3'd2;
      3: return 3'd3;
      4: return 3'd4;
      5: return 3'd0;
      6: return 3'd5;
      7: return 3'd4;
      8: return 3'd6;
      default: return 3'($urandom_range(7, 0));
    endcase
  endfunction

  task automatic check_cycle();
    int p, h, v, f, ax, ay;
    logic ehs, evs, ede, efs;
    logic [23:0] erg;
    logic [15:0] efc;
    logic [11:0] ex, ey;
    p = n - 2; f = 0; ax = -1; ay = -1;
    ehs = 1'b1; evs = 1'b1; ede = 1'b0; efs = 1'b0; erg = 24'h0; efc = 16'h0;
    if (p >= 0) begin
      h = p % HT; v = (p / HT) % VT; f = p / FT;
      ax = h - HAS; ay = v - VAS;
      ehs = (h >= HS);
      evs = (v >= VS);
      ede = (ax >= 0 && ax < HA && ay >= 0 && ay < VA);
      efs = (p % FT == 0);
      efc = 16'(f + 1);
      if (ede) erg = exp_rgb(ax, ay, f, fmode[f % 64], fsolid[f % 64]);
    end
    check_val("hs", 32'(hs_out), 32'(ehs));
    check_val("vs", 32'(vs_out), 32'(evs));
    check_val("de", 32'(de_out), 32'(ede));
    check_val("rgb", 32'({r_out, g_out, b_out}), 32'(erg));
    check_val("fstart", 32'(frame_start), 32'(efs));
    check_val("fcnt", 32'(frame_cnt), 32'(efc));
    if (ede && fmode[f % 64] == 3'd4 && ax == 5 && ay == 0)
      check_val("ext_x5", 32'({r_out, g_out, b_out}), 32'(EXT_FULL));
    h = n % HT; v = (n / HT) % VT;
    ax = h - HAS; ay = v - VAS;
    ex = 12'hFFF; ey = 12'hFFF;
    if (ax >= 0 && ax < HA && ay >= 0 && ay < VA) begin
      ex = 12'(ax); ey = 12'(ay);
    end
    check_val("pix_x", 32'(pix_x), 32'(ex));
    check_val("pix_y", 32'(pix_y), 32'(ey));
  endtask

  task automatic drive();
    int h, v, fq, off;
    h = n % HT; v = (n / HT) % VT; fq = n / FT; off = n % FT;
    if (off == 0) begin
      chg_at = int'($urandom_range(FT - 2, 1));
      nxt_mode = plan(fq + 1);
    end
    if (off == chg_at) mode_sel = nxt_mode;
    if (h == 5 && v == 0) begin
      solid_rgb = (fq == 3) ? 24'h123456 : 24'($urandom);
      fsolid[fq % 64] = solid_rgb;
    end
    if (off == FT - 1) fmode[(fq + 1) % 64] = mode_sel;
    ext_pix_data = src(prev_x, prev_y);
    prev_x = pix_x;
    prev_y = pix_y;
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(posedge vga_clk);
      n++;
      @(negedge vga_clk);
      check_cycle();
      drive();
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ext_tab[i] = 16'($urandom);
    ext_tab[5] = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      fmode[i] = 3'd0;
      fsolid[i] = 24'h0;
    end
    n = 0;
    repeat (3) begin
      @(negedge vga_clk);
      check_cycle();
      drive();
    end
    sys_rst_n = 1'b1;
    run(12 * FT);
    while (n % FT != 8 * HT + 20) run(1);

    #2 sys_rst_n = 1'b0;
    #1 n = 0;
    fmode[0] = 3'd0;
    check_cycle();
    repeat (2) begin
      @(negedge vga_clk);
      check_cycle();
      drive();
    end
    sys_rst_n = 1'b1;
    run(2);
    check_val("rst_fstart", 32'(frame_start), 32'd1);
    check_val("rst_fcnt", 32'(frame_cnt), 32'd1);
    run(6 * FT);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
